// File: rtl/rr_grant_encoder_16.sv
// 16-way round-robin grant scheduler driving a 4:16 decoder (encoded index + enable).
// Optional build macro RR_GUARD_CYCLE_EN inserts a one-cycle break-before-make gap between grants.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no grant active, arbitrate every cycle
// ST_GRANT | grant active, hold counter running, watch for termination
// ST_GUARD | (RR_GUARD_CYCLE_EN only) one dead cycle after a termination

module rr_grant_encoder_16 #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic        Clk_In,
    input  logic        Rst_n_In,
    input  logic [15:0] Request_In,
    input  logic        Ack_In,
    output logic [3:0]  Encoded_Value_Out,
    output logic        Enable_Out,
    output logic        Grant_Done_Out
);

`ifdef RR_GUARD_CYCLE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1
    } state_t;
`endif

    localparam logic [CNT_WIDTH-1:0] HOLD_CNT = CNT_WIDTH'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [3:0]           r_last_grant;
    logic [3:0]           r_enc;
    logic                 r_en;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [3:0]           w_last_nxt;
    logic [3:0]           w_enc_nxt;
    logic                 w_en_nxt;
    logic                 w_done_nxt;

    logic [3:0]           w_idx;
    logic [3:0]           w_winner;
    logic                 w_found;
    logic                 w_term;

    // Rotating search: last grant + 1 first, last grant itself checked last.
    always_comb begin
        w_idx    = 4'd0;
        w_winner = r_last_grant;
        w_found  = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            w_idx = r_last_grant + 4'(i);
            if (!w_found && Request_In[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_term = 1'b0;
        if (r_state == ST_GRANT) begin
            w_term = (r_cnt == HOLD_CNT) || Ack_In || !Request_In[r_enc];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last_grant;
        w_enc_nxt   = r_enc;
        w_en_nxt    = r_en;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_cnt_nxt   = CNT_ONE;
                    w_last_nxt  = w_winner;
                    w_enc_nxt   = w_winner;
                    w_en_nxt    = 1'b1;
                end
            end

            ST_GRANT: begin
                if (w_term) begin
                    w_done_nxt = 1'b1;
`ifdef RR_GUARD_CYCLE_EN
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b0;
`else
                    if (w_found) begin
                        w_state_nxt = ST_GRANT;
                        w_cnt_nxt   = CNT_ONE;
                        w_last_nxt  = w_winner;
                        w_enc_nxt   = w_winner;
                        w_en_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_en_nxt    = 1'b0;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

`ifdef RR_GUARD_CYCLE_EN
            ST_GUARD: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_cnt_nxt   = CNT_ONE;
                    w_last_nxt  = w_winner;
                    w_enc_nxt   = w_winner;
                    w_en_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk_In) begin
        if (!Rst_n_In) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 4'd15;
            r_enc        <= 4'd0;
            r_en         <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_nxt;
            r_enc        <= w_enc_nxt;
            r_en         <= w_en_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign Encoded_Value_Out = r_enc;
    assign Enable_Out        = r_en;
    assign Grant_Done_Out    = r_done;

endmodule
